// File: rtl/sr_latch_driver_pkg.sv
// sr_drv_pkg: shared states, error codes and counter sizing for the SR latch driver
package sr_drv_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, CHECK} state_t;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_INVALID = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  function automatic int cnt_width(input int p, input int t);
    return $clog2((p > t ? p : t) + 1);
  endfunction
endpackage

// File: rtl/sr_latch_driver_sync_ff.sv
// sync_ff: multi-stage single-bit synchronizer with async active-high clear
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;
  // shift the asynchronous input through the flop chain
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else sr <= {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: pulses an external NAND SR latch and confirms its state via synchronized feedback
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_set,
  output logic       cmd_ready,
  output logic       s_n,
  output logic       r_n,
  input  logic       q_fb,
  input  logic       qn_fb,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       state_q
);
  localparam int CW = cnt_width(PULSE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] PMAX  = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);
  state_t st;
  logic cmd;
  logic [CW-1:0] cnt;
  logic inv_prev;
  logic q_s;
  logic qn_s;
  logic match;
  logic invalid;
  sync_ff #(.STAGES(SYNC_STAGES)) u_q  (.clk(clk), .rst(rst), .d(q_fb),  .q(q_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_qn (.clk(clk), .rst(rst), .d(qn_fb), .q(qn_s));
  // classify the synchronized feedback against the commanded state
  always_comb begin
    match   = (q_s == cmd) && (qn_s != cmd);
    invalid = q_s && qn_s;
  end
  // command FSM: accept, hold the selected line low, then confirm or time out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st        <= IDLE;
      cmd       <= 1'b0;
      cnt       <= '0;
      inv_prev  <= 1'b0;
      s_n       <= 1'b1;
      r_n       <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      state_q   <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (st)
        IDLE:
          if (cmd_valid && cmd_ready) begin
            cmd       <= cmd_set;
            err_code  <= ERR_NONE;
            cnt       <= CW'(1);
            s_n       <= ~cmd_set;
            r_n       <= cmd_set;
            cmd_ready <= 1'b0;
            st        <= PULSE;
          end else cmd_ready <= 1'b1;
        PULSE:
          if (cnt >= PMAX) begin
            s_n      <= 1'b1;
            r_n      <= 1'b1;
            cnt      <= '0;
            inv_prev <= 1'b0;
            st       <= CHECK;
          end else cnt <= cnt + CW'(1);
        CHECK:
          if (match) begin
            done      <= 1'b1;
            state_q   <= cmd;
            cmd_ready <= 1'b1;
            st        <= IDLE;
          end else if (invalid && inv_prev) begin
            err       <= 1'b1;
            err_code  <= ERR_INVALID;
            cmd_ready <= 1'b1;
            st        <= IDLE;
          end else if (cnt >= TLAST) begin
            err       <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            cmd_ready <= 1'b1;
            st        <= IDLE;
          end else begin
            cnt      <= cnt + CW'(1);
            inv_prev <= invalid;
          end
        default: st <= IDLE;
      endcase
    end
  // the latch must never see both inputs asserted at once
  a_excl: assert property (@(posedge clk) disable iff (rst) s_n || r_n);
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: scoreboard bench with a behavioural NAND latch and forced-feedback scenarios
module tb_sr_latch_driver;
  import sr_drv_pkg::*;
  localparam int P = 4;
  localparam int T = 16;
  localparam int S = 2;
  typedef struct {
    logic       d;
    logic       e;
    logic [1:0] code;
    logic       st;
    int         lat;
  } exp_t;
  logic clk = 0;
  logic clk_en = 0;
  logic rst;
  logic cmd_valid;
  logic cmd_set;
  logic cmd_ready;
  logic s_n;
  logic r_n;
  logic q_fb;
  logic qn_fb;
  logic done;
  logic err;
  logic [1:0] err_code;
  logic state_q;
  logic fb_mode;
  logic fq;
  logic fqn;
  logic lq = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;
  exp_t sb[$];
  sr_latch_driver #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(T), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_set(cmd_set), .cmd_ready(cmd_ready),
    .s_n(s_n), .r_n(r_n), .q_fb(q_fb), .qn_fb(qn_fb), .done(done), .err(err),
    .err_code(err_code), .state_q(state_q)
  );
  always #5 if (clk_en) clk = ~clk;
  // behavioural NAND latch: low set forces q=1, low reset forces q=0, otherwise hold
  always @(s_n or r_n) begin
    if (!s_n) lq = 1'b1;
    else if (!r_n) lq = 1'b0;
  end
  assign q_fb  = fb_mode ? fq : lq;
  assign qn_fb = fb_mode ? fqn : ~lq;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // cycle counter and accept-edge tracking for latency checks
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && cmd_valid && cmd_ready) e0 <= cyc + 1;
  end
  // monitor: pop expectation on every done/err pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("excl", {31'b0, s_n | r_n}, 1);
      if (done || err) begin
        if (sb.size() == 0) check("unexpected_resp", {30'b0, done, err}, 0);
        else begin
          e = sb.pop_front();
          check("done", {31'b0, done}, {31'b0, e.d});
          check("err", {31'b0, err}, {31'b0, e.e});
          check("err_code", {30'b0, err_code}, {30'b0, e.code});
          check("state_q", {31'b0, state_q}, {31'b0, e.st});
          if (e.lat >= 0) check("latency", cyc - e0, e.lat);
        end
      end
    end
  end
  task automatic expect_resp(input logic d, input logic e, input logic [1:0] code, input logic st, input int lat);
    exp_t x;
    x.d = d; x.e = e; x.code = code; x.st = st; x.lat = lat;
    sb.push_back(x);
  endtask
  task automatic issue(input logic set, input logic b2b);
    int n = 0;
    cmd_valid = 1;
    cmd_set = set;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("accept_timeout", {31'b0, cmd_ready}, 1);
    if (b2b) check("b2b_done_cycle", {31'b0, done}, 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic pulse_check(input logic set);
    for (int i = 0; i < P; i++) begin
      check("s_n_pulse", {31'b0, s_n}, {31'b0, !set});
      check("r_n_pulse", {31'b0, r_n}, {31'b0, set});
      check("busy_ready", {31'b0, cmd_ready}, 0);
      if (i == 0) check("err_code_clr", {30'b0, err_code}, ERR_NONE);
      @(negedge clk);
    end
    check("s_n_release", {31'b0, s_n}, 1);
    check("r_n_release", {31'b0, r_n}, 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !cmd_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("resp_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask
  initial begin
    rst = 1; cmd_valid = 0; cmd_set = 0; fb_mode = 0; fq = 0; fqn = 1;
    #3;
    check("rst_s_n", {31'b0, s_n}, 1);
    check("rst_r_n", {31'b0, r_n}, 1);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_err_code", {30'b0, err_code}, ERR_NONE);
    check("rst_state_q", {31'b0, state_q}, 0);
    check("rst_ready", {31'b0, cmd_ready}, 0);
    clk_en = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, cmd_ready}, 1);
    expect_resp(1, 0, ERR_NONE, 1, P + 1);
    issue(1, 0);
    cmd_valid = 1;
    cmd_set = 0;
    pulse_check(1);
    cmd_valid = 0;
    wait_idle();
    expect_resp(1, 0, ERR_NONE, 0, P + 1);
    issue(0, 0);
    pulse_check(0);
    expect_resp(1, 0, ERR_NONE, 0, P + 1);
    issue(0, 1);
    pulse_check(0);
    wait_idle();
    fb_mode = 1; fq = 0; fqn = 1;
    repeat (3) @(negedge clk);
    expect_resp(0, 1, ERR_TIMEOUT, 0, P + T);
    issue(1, 0);
    pulse_check(1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("err_code_hold", {30'b0, err_code}, ERR_TIMEOUT);
    fq = 1; fqn = 1;
    repeat (3) @(negedge clk);
    expect_resp(0, 1, ERR_INVALID, 0, P + 2);
    issue(1, 0);
    pulse_check(1);
    wait_idle();
    fq = 0; fqn = 1;
    repeat (3) @(negedge clk);
    expect_resp(1, 0, ERR_NONE, 1, 10);
    issue(1, 0);
    pulse_check(1);
    @(negedge clk);
    @(negedge clk);
    fq = 1; fqn = 1;
    @(negedge clk);
    fq = 1; fqn = 0;
    wait_idle();
    fb_mode = 0;
    repeat (2) @(negedge clk);
    issue(1, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    check("midrst_s_n", {31'b0, s_n}, 1);
    check("midrst_r_n", {31'b0, r_n}, 1);
    check("midrst_ready", {31'b0, cmd_ready}, 0);
    @(negedge clk);
    rst = 0;
    repeat (30) @(negedge clk);
    check("ready_after_midrst", {31'b0, cmd_ready}, 1);
    check("no_pending", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
